zero_merge_dec: RTL and testbench
=================================

// Module: zero_merge_dec
// PURPOSE
//  Decoder-side block reassembler. It merges the zero/non-zero (ZNZ) flag stream and the bit-plane (BPC) value stream back into one word stream.
//  - Each ZNZ flag yields one output word: 0 if the flag is 0, otherwise the next BPC value.
//  - last_o marks word BLOCK_SIZE-1 of each block; blk_done_o pulses when that word is accepted downstream.
//  - Sits between the ZNZ/BPC decoders and the decompressor output port.
// PARAMETERS
//  DATA_W      8  width of a data word / BPC value
//  BLOCK_SIZE  8  words per block (>=2); counter width CNT_W=$clog2(BLOCK_SIZE)
// PORTS
//  clk_i       in   1       clock
//  rst_ni      in   1       reset, asynchronous, active-low
//  znz_i       in   1       ZNZ flag (1 = non-zero word)
//  znz_vld_i   in   1       ZNZ stream valid
//  znz_rdy_o   out  1       ZNZ stream ready
//  bpc_data_i  in   DATA_W  decoded non-zero value
//  bpc_last_i  in   1       final BPC value of current block
//  bpc_vld_i   in   1       BPC stream valid
//  bpc_rdy_o   out  1       BPC stream ready
//  data_o      out  DATA_W  reassembled word
//  last_o      out  1       word is last of block
//  vld_o       out  1       output valid
//  rdy_i       in   1       output ready
//  blk_done_o  out  1       1-cycle pulse: last word handshaked
//  err_o       out  1       sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: data_o=0, last_o=0, vld_o=0, blk_done_o=0, err_o=0, word cnt=0, state IDLE, bpc_last_seen=0.
//  - Output register slice. can_acc = ~vld_o | rdy_i.
//    - Accepted input appears on the outputs the next cycle (latency 1).
//    - Throughput is 1 word/cycle.
//  - Input take condition: take = (state!=LAST_OUT) & can_acc & znz_vld_i & (~znz_i | bpc_vld_i).
//  - Ready outputs:
//    - znz_rdy_o = (state!=LAST_OUT) & can_acc & (~znz_i | bpc_vld_i).
//    - bpc_rdy_o = take & znz_i.
//    - Both streams therefore pop in the same cycle for a non-zero word.
//    - A zero word never pops BPC. The BPC value is held, and may be valid, while zeros flow.
//  - Combinational vld->rdy paths exist across streams. No ready output depends on rdy_i through state only.
//    - vld_o never depends on rdy_i.
//  - FSM:
//    - IDLE: take -> ACTIVE. If BLOCK_SIZE words are already taken (n/a, since BLOCK_SIZE>=2), stay.
//    - ACTIVE: take with cnt==BLOCK_SIZE-1 -> LAST_OUT. This registers last_o=1 and resets cnt to 0.
//    - LAST_OUT: no input taken. On vld_o&rdy_i: blk_done_o=1 (same cycle, comb from state and handshake) -> IDLE.
//  - Counter: cnt increments on each take and wraps to 0 on the last word of a block. bpc_last_seen clears on the block wrap.
//  - Simultaneous events: the LAST_OUT handshake and a new input valid in the same cycle do NOT take input. The new block starts at least 1 cycle later; this guarantees blk_done is distinct per block.
//  - Stall: non-zero flag with ~bpc_vld_i -> no pops, no output; the state is held.
//  - Reset mid-block: the partial block is discarded, with no blk_done or last_o.
// CONFIGURATION
//  Macro ZERO_MERGE_DEC_CHECK_EN.
//  With the macro defined, err_o is set (sticky until reset) when either:
//    (a) a non-zero flag is taken while bpc_last_seen=1 (BPC ended too early), or
//    (b) the block's last word is taken, the block held >=1 non-zero word, and neither bpc_last_seen nor the current pop carried bpc_last_i (BPC overrun).
//  - An all-zero block expects no BPC traffic, so no error is raised for it.
//  - Data flow is unaffected by errors.
//  Without the macro: err_o is tied to 0, bpc_last_i is ignored, and the checker flops are absent.
// STRUCTURE
//  - Package ebpc_dec_pkg holds:
//    - the typedef enum logic [1:0] {IDLE, ACTIVE, LAST_OUT} zmd_state_t;
//    - default DATA_W and BLOCK_SIZE localparams.
//  - Sub-module zmd_out_reg: a DATA_W+1 bit valid/ready register slice for data and last, exposing can_acc.
//  - The FSM, counter and checker stay in the top module.
// TESTING
//  1. BLOCK_SIZE=8, rdy_i=1. Flags 0,1,0,0,1,0,0,1 with BPC values 0x11,0x22,0x33 (last on 0x33).
//     -> Output 0,11,0,0,22,0,0,33. last_o only on word 8. blk_done one cycle. err_o=0.
//  2. All-zero block of 8 flags with bpc_vld_i=0 throughout.
//     -> 8 zero words; bpc_rdy_o never 1; blk_done pulses; err_o=0.
//  3. Non-zero flag arrives with bpc_vld_i low for 5 cycles.
//     -> znz_rdy_o=0, no output for 5 cycles. Resumes on bpc_vld_i; the value appears 1 cycle later.
//  4. rdy_i toggled 1,0,0,1 with back-to-back blocks.
//     -> No word lost or duplicated. Block 2's first input is taken only after the LAST_OUT handshake; one blk_done per block.
//  5. CHECK_EN: bpc_last_i on 1st of 2 non-zeros -> err_o=1 at the 2nd take.
//     Separately, no bpc_last in a block with non-zeros -> err_o=1 at the last take.
//  6. Assert rst_ni mid-block after 3 words.
//     -> All outputs 0 immediately. The next block has 8 words with last_o on word 8.

Source files
------------

// File: rtl/ebpc_dec_pkg.sv
// rtl/ebpc_dec_pkg.sv - shared types and defaults for the EBPC decoder blocks
package ebpc_dec_pkg;

    localparam int ZMD_DATA_W     = 8;
    localparam int ZMD_BLOCK_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        LAST_OUT = 2'd2
    } zmd_state_t;

endpackage

// File: rtl/zmd_out_reg.sv
// rtl/zmd_out_reg.sv - single-entry valid/ready register slice exposing can_acc
module zmd_out_reg #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] in_data,
    input  logic         in_vld,
    output logic         can_acc,
    output logic [W-1:0] out_data,
    output logic         out_vld,
    input  logic         out_rdy
);

    // The slice can load whenever it is empty or its word leaves this cycle
    assign can_acc = ~out_vld | out_rdy;

    // Capture a new word when allowed; data holds its value while invalid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (can_acc) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/zero_merge_dec.sv
// rtl/zero_merge_dec.sv - merges ZNZ flags and BPC values into a word stream (optional checker: ZERO_MERGE_DEC_CHECK_EN)
module zero_merge_dec
    import ebpc_dec_pkg::*;
#(
    parameter int DATA_W     = ZMD_DATA_W,
    parameter int BLOCK_SIZE = ZMD_BLOCK_SIZE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              znz_i,
    input  logic              znz_vld_i,
    output logic              znz_rdy_o,
    input  logic [DATA_W-1:0] bpc_data_i,
    input  logic              bpc_last_i,
    input  logic              bpc_vld_i,
    output logic              bpc_rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              blk_done_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);

    zmd_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              can_acc;
    logic              take;
    logic              is_last_word;
    logic [DATA_W-1:0] word;
    logic [DATA_W:0]   slice_out;

    // While the last word of a block waits downstream, no new input enters
    assign znz_rdy_o    = (state_q != LAST_OUT) & can_acc & (~znz_i | bpc_vld_i);
    assign take         = znz_rdy_o & znz_vld_i;
    assign bpc_rdy_o    = take & znz_i;
    assign is_last_word = (cnt_q == CNT_LAST);
    assign word         = znz_i ? bpc_data_i : '0;
    assign blk_done_o   = (state_q == LAST_OUT) & vld_o & rdy_i;

    zmd_out_reg #(
        .W (DATA_W + 1)
    ) u_out_reg (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .in_data  ({is_last_word, word}),
        .in_vld   (take),
        .can_acc  (can_acc),
        .out_data (slice_out),
        .out_vld  (vld_o),
        .out_rdy  (rdy_i)
    );

    assign last_o = slice_out[DATA_W];
    assign data_o = slice_out[DATA_W-1:0];

    // Block sequencing: count taken words, park in LAST_OUT until the last word leaves
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, ACTIVE: begin
                if (take) begin
                    if (is_last_word) begin
                        state_d = LAST_OUT;
                        cnt_d   = '0;
                    end else begin
                        state_d = ACTIVE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            LAST_OUT: begin
                if (vld_o && rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and word counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ZERO_MERGE_DEC_CHECK_EN
    logic bpc_last_seen_q;
    logic nz_seen_q;
    logic err_q;
    logic err_early;
    logic err_overrun;

    // BPC ended before this block ran out of non-zero flags
    assign err_early   = take & znz_i & bpc_last_seen_q;
    // Block closes with non-zero words but BPC never signalled its end
    assign err_overrun = take & is_last_word & (nz_seen_q | znz_i)
                       & ~bpc_last_seen_q & ~(znz_i & bpc_last_i);

    // Per-block BPC bookkeeping plus the sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bpc_last_seen_q <= 1'b0;
            nz_seen_q       <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            if (take) begin
                if (is_last_word) begin
                    bpc_last_seen_q <= 1'b0;
                    nz_seen_q       <= 1'b0;
                end else begin
                    bpc_last_seen_q <= bpc_last_seen_q | (znz_i & bpc_last_i);
                    nz_seen_q       <= nz_seen_q | znz_i;
                end
            end
            err_q <= err_q | err_early | err_overrun;
        end
    end

    assign err_o = err_q;
`else
    logic unused_bpc_last;
    assign unused_bpc_last = bpc_last_i;
    assign err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_zero_merge_dec.sv
// tb/tb_zero_merge_dec.sv - randomized self-checking bench for zero_merge_dec
module tb_zero_merge_dec;

    localparam int DW = 8;
    localparam int BS = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          znz_i = 1'b0, znz_vld_i = 1'b0, znz_rdy_o;
    logic [DW-1:0] bpc_data_i = '0;
    logic          bpc_last_i = 1'b0, bpc_vld_i = 1'b0, bpc_rdy_o;
    logic [DW-1:0] data_o;
    logic          last_o, vld_o, rdy_i = 1'b0, blk_done_o, err_o;

    zero_merge_dec #(.DATA_W(DW), .BLOCK_SIZE(BS)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .znz_i(znz_i), .znz_vld_i(znz_vld_i), .znz_rdy_o(znz_rdy_o),
        .bpc_data_i(bpc_data_i), .bpc_last_i(bpc_last_i),
        .bpc_vld_i(bpc_vld_i), .bpc_rdy_o(bpc_rdy_o),
        .data_o(data_o), .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i),
        .blk_done_o(blk_done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus streams and the expected output word sequence ({last, data})
    bit         zq[$];
    logic [8:0] bq[$];
    logic [8:0] exp_q[$];

    // Reference view of what sits in the output register and block progress
    bit         m_vld, m_last, m_err, m_bls, m_nz;
    logic [7:0] m_data;
    int         m_cnt;

    int         done_cnt = 0, bpc_pops = 0;
    logic [7:0] log_q[$];
    logic [7:0] lpack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // vmode 0: random values, 1: 0x11,0x22,...; lmode 0: last on final nz, 1: on first nz, 2: never
    task automatic push_block(input logic [7:0] flags, input int vmode, input int lmode);
        int nnz, k;
        logic [7:0] v;
        bit lb;
        nnz = $countones(flags);
        k = 0;
        for (int i = 0; i < BS; i++) begin
            zq.push_back(flags[i]);
            if (flags[i]) begin
                k++;
                v  = (vmode == 1) ? 8'(8'h11 * k) : 8'($urandom);
                lb = (lmode == 0) ? (k == nnz) : (lmode == 1) ? (k == 1) : 1'b0;
                bq.push_back({lb, v});
                exp_q.push_back({(i == BS - 1), v});
            end else begin
                exp_q.push_back({(i == BS - 1), 8'h00});
            end
        end
    endtask

    task automatic step(input int pz, input int pb, input int pr);
        bit can, e_zr, e_take, nl;
        logic [7:0] nd;
        logic [8:0] e;
        @(negedge clk);
        znz_vld_i = (zq.size() > 0) && ($urandom_range(99) < pz);
        znz_i     = (zq.size() > 0) ? zq[0] : 1'b0;
        bpc_vld_i = (bq.size() > 0) && ($urandom_range(99) < pb);
        {bpc_last_i, bpc_data_i} = (bq.size() > 0) ? bq[0] : 9'h0;
        rdy_i     = ($urandom_range(99) < pr);
        #1;
        // A held last-of-block word blocks intake until it has been handshaked
        can    = !m_vld || rdy_i;
        e_zr   = !(m_vld && m_last) && can && (!znz_i || bpc_vld_i);
        e_take = e_zr && znz_vld_i;
        chk("znz_rdy", znz_rdy_o, e_zr);
        chk("bpc_rdy", bpc_rdy_o, e_take && znz_i);
        chk("vld", vld_o, m_vld);
        if (m_vld) begin
            chk("data", data_o, m_data);
            chk("last", last_o, m_last);
        end
        chk("blk_done", blk_done_o, m_vld && m_last && rdy_i);
        chk("err", err_o, m_err);
        if (bpc_rdy_o) bpc_pops++;
        if (blk_done_o) done_cnt++;
        if (vld_o && rdy_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got word %0h expected none", data_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", data_o, e[7:0]);
                chk("sb_last", last_o, e[8]);
            end
            log_q.push_back(data_o);
            lpack = {last_o, lpack[7:1]};
        end
        if (e_take) begin
            nl = (m_cnt == BS - 1);
            nd = znz_i ? bpc_data_i : 8'h00;
`ifdef ZERO_MERGE_DEC_CHECK_EN
            if (znz_i && m_bls) m_err = 1'b1;
            if (nl && (m_nz || znz_i) && !m_bls && !(znz_i && bpc_last_i)) m_err = 1'b1;
            if (nl) begin
                m_bls = 1'b0;
                m_nz  = 1'b0;
            end else begin
                m_bls = m_bls || (znz_i && bpc_last_i);
                m_nz  = m_nz || znz_i;
            end
`endif
            m_cnt = nl ? 0 : m_cnt + 1;
            void'(zq.pop_front());
            if (znz_i) void'(bq.pop_front());
        end
        if (can) begin
            m_vld = e_take;
            if (e_take) begin
                m_data = nd;
                m_last = nl;
            end
        end
    endtask

    task automatic drain(input int pz, input int pb, input int pr, input int budget);
        int c;
        c = 0;
        while ((zq.size() > 0 || exp_q.size() > 0) && c < budget) begin
            step(pz, pb, pr);
            c++;
        end
        chk("drain_left", zq.size() + exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        znz_vld_i = 1'b0;
        bpc_vld_i = 1'b0;
        #1;
        chk("rst_vld", vld_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_done", blk_done_o, 0);
        chk("rst_err", err_o, 0);
        zq.delete();
        bq.delete();
        exp_q.delete();
        m_vld = 0; m_last = 0; m_data = 0; m_cnt = 0;
        m_err = 0; m_bls = 0; m_nz = 0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        int d0, p0, c;
        bit exp_err;
        logic [7:0] t1_exp [8];
        t1_exp = '{8'h00, 8'h11, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h33};
        do_reset();

        // Test 1: mixed block, downstream always ready
        log_q.delete(); lpack = '0; d0 = done_cnt;
        push_block(8'b1001_0010, 1, 0);
        drain(100, 100, 100, 40);
        chk("t1_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < log_q.size()) chk("t1_word", log_q[i], t1_exp[i]);
        chk("t1_lastpos", lpack, 8'h80);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", err_o, 0);

        // Test 2: all-zero block never touches BPC
        log_q.delete(); lpack = '0; d0 = done_cnt; p0 = bpc_pops;
        push_block(8'h00, 1, 0);
        drain(100, 0, 100, 40);
        chk("t2_bpc_pops", bpc_pops - p0, 0);
        chk("t2_count", log_q.size(), 8);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_err", err_o, 0);

        // Test 3: non-zero flag stalls while BPC is empty
        push_block(8'b0000_0001, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(100, 0, 100);
            chk("t3_stall_rdy", znz_rdy_o, 0);
            chk("t3_stall_vld", vld_o, 0);
        end
        step(100, 100, 100);
        step(100, 100, 100);
        chk("t3_resume_vld", vld_o, 1);
        chk("t3_resume_data", data_o, 8'h11);
        drain(100, 100, 100, 40);

        // Test 4: back-to-back blocks under rdy pattern 1,0,0,1
        log_q.delete(); d0 = done_cnt;
        for (int b = 0; b < 3; b++) push_block(8'($urandom), 0, 0);
        c = 0;
        while ((zq.size() > 0 || exp_q.size() > 0) && c < 200) begin
            step(100, 100, (c % 4 == 1 || c % 4 == 2) ? 0 : 100);
            c++;
        end
        chk("t4_drain_left", zq.size() + exp_q.size(), 0);
        chk("t4_count", log_q.size(), 24);
        chk("t4_done", done_cnt - d0, 3);

        // Random traffic
        d0 = done_cnt;
        for (int b = 0; b < 30; b++) push_block(8'($urandom), 0, 0);
        drain(70, 70, 70, 3000);
        chk("rand_done", done_cnt - d0, 30);

        // Test 5: BPC stream markers out of step with the flags
`ifdef ZERO_MERGE_DEC_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        push_block(8'b0000_0011, 1, 1);
        drain(100, 100, 100, 40);
        chk("t5_early_err", err_o, exp_err);
        do_reset();
        push_block(8'b0100_1000, 1, 2);
        drain(100, 100, 100, 40);
        chk("t5_overrun_err", err_o, exp_err);
        do_reset();

        // Test 6: reset after three words, then a clean block
        push_block(8'b1010_0101, 1, 0);
        c = 0;
        while (m_cnt != 3 && c < 20) begin
            step(100, 100, 100);
            c++;
        end
        chk("t6_reached_3", m_cnt, 3);
        do_reset();
        log_q.delete(); lpack = '0; d0 = done_cnt;
        push_block(8'b0110_1100, 1, 0);
        drain(100, 100, 100, 40);
        chk("t6_count", log_q.size(), 8);
        chk("t6_lastpos", lpack, 8'h80);
        chk("t6_done", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
